sc_accum_sequencer: RTL and testbench
=====================================

SC_ACCUM_SEQUENCER -- requirements
Module: sc_accum_sequencer

Interface
REQ-001 SHALL have parameter K, default 3, log2 of the bitstream lane count.
REQ-002 SHALL have parameter N, default 2**K, the number of parallel stochastic bitstream lanes.
REQ-003 SHALL have parameter LW, default 8, the width of the window-length field.
REQ-004 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: start  input  1  request to begin one accumulation window.
REQ-007 SHALL have ports: len  input  LW  window length in accepted beats, sampled on start.
REQ-008 SHALL have ports: data_in  input  N  one parallel bitstream beat.
REQ-009 SHALL have ports: in_valid  input  1  data_in holds a beat.
REQ-010 SHALL have ports: in_ready  output  1  block accepts a beat this cycle.
REQ-011 SHALL have ports: sum  output  LW+K  accumulated ones count.
REQ-012 SHALL have ports: out_valid  output  1  sum is final.
REQ-013 SHALL have ports: out_ready  input  1  consumer takes sum.
REQ-014 SHALL have ports: busy  output  1  window in progress or result pending.
REQ-015 SHALL have ports: err  output  1  one-cycle pulse on rejected start.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE, with IDLE entered from reset.
REQ-017 In IDLE: in_ready=0, busy=0, out_valid=0.
REQ-018 In IDLE, start=1 with len!=0: latch len, clear sum and beat counter to 0, enter RUN next cycle.
REQ-019 In IDLE, start=1 with len==0: pulse err=1 for exactly one cycle, remain in IDLE, leave sum unchanged.
REQ-020 In RUN: in_ready=1 and busy=1; a beat is accepted only when in_valid&in_ready.
REQ-021 On each accepted beat: sum += popcount(data_in) (0..N) and beat counter += 1.
REQ-022 Cycles with in_valid=0 SHALL leave sum and beat counter unchanged (stall, no timeout).
REQ-023 When the accepted beat is number len: transition to DONE; sum includes that beat on the following cycle.
REQ-024 In DONE: out_valid=1, busy=1, in_ready=0; sum is held stable.
REQ-025 In DONE, out_valid&out_ready returns the block to IDLE, with out_valid=0 on the next cycle.
REQ-026 start SHALL be ignored in RUN and DONE (no err pulse, no restart).
REQ-027 Latency: with start at cycle t and in_valid held at 1, beats are accepted t+1..t+len and out_valid=1 at cycle t+len+1.
REQ-028 Width: worst case (2^LW-1)*N < 2^(LW+K), so sum SHALL never overflow or wrap.
REQ-029 sum SHALL show the running accumulator in RUN; it is valid for consumers only while out_valid=1.
REQ-030 All outputs SHALL be registered except in_ready, busy and out_valid, which SHALL decode directly from state.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, sum=0, beat counter=0, latched len=0, err=0, out_valid=0, in_ready=0, busy=0, at any time including mid-RUN and during DONE.
REQ-032 After rst_n deasserts, the first start SHALL behave exactly as in REQ-018, with no residue from the aborted window.

Verification
REQ-033 Reset: assert rst_n=0 between clock edges -> all outputs 0 before the next edge; state IDLE.
REQ-034 K=3, start with len=4, data_in=8'hFF, in_valid=1 -> out_valid rises 5 cycles after start, sum=32; out_ready=1 -> IDLE next cycle.
REQ-035 len=3, beats 8'h01, 8'h0F, 8'hA5, with in_valid=0 for two cycles between beats -> sum=9; bubbles not counted; out_valid rises one cycle after the third beat.
REQ-036 start with len=0 -> err=1 for one cycle, busy stays 0, sum unchanged; start with len=255 and all-ones beats -> sum=2040, no overflow.
REQ-037 In DONE, hold out_ready=0 for 3 cycles and pulse start -> sum and out_valid held, no err, no restart; out_ready=1 -> IDLE.
REQ-038 rst_n=0 after 2 accepted beats of a len=4 window -> outputs cleared at once; a new start with len=1 and beat 8'h03 -> sum=2.

Source files
------------

// File: rtl/sc_accum_sequencer.sv
// sc_accum_sequencer
//   Counts the ones in a window of parallel stochastic bitstream beats.
//   A start with a non-zero len opens a window of len accepted beats. The
//   ones count of every accepted beat is added to sum. The final count is
//   then held under a valid/ready handshake until the consumer takes it.
//
// Ports
//   clk        single clock, all state on rising edge
//   rst_n      asynchronous, active-low reset
//   start      request to begin one accumulation window
//   len        window length in accepted beats, sampled on start
//   data_in    one N-lane bitstream beat
//   in_valid   data_in holds a beat
//   in_ready   block accepts a beat this cycle (decoded from state)
//   sum        accumulated ones count (registered)
//   out_valid  sum is final (decoded from state)
//   out_ready  consumer takes sum
//   busy       window in progress or result pending (decoded from state)
//   err        one-cycle pulse on a start with len == 0 (registered)
module sc_accum_sequencer #(
  parameter int K  = 3,
  parameter int N  = 2**K,
  parameter int LW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [LW-1:0]   len,
  input  logic [N-1:0]    data_in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [LW+K-1:0] sum,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   cnt;
  logic [K:0]      pop;
  logic            accept;
  logic            last_beat;
  logic            start_ok;
  logic            start_bad;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pop = pop + {{K{1'b0}}, data_in[i]};
    end
  end

  assign in_ready  = (state == RUN);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  assign accept    = in_valid & in_ready;
  assign last_beat = accept & ((cnt + 1'b1) == len_q);
  assign start_ok  = (state == IDLE) & start & (len != '0);
  assign start_bad = (state == IDLE) & start & (len == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (last_beat) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      cnt   <= '0;
      len_q <= '0;
      err   <= 1'b0;
    end else begin
      err <= start_bad;
      if (start_ok) begin
        len_q <= len;
        sum   <= '0;
        cnt   <= '0;
      end else if (accept) begin
        sum <= sum + {{(LW-1){1'b0}}, pop};
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sc_accum_sequencer.sv
// Directed bench for sc_accum_sequencer with K=3, N=8, LW=8.
module tb_sc_accum_sequencer;

  localparam int K  = 3;
  localparam int N  = 8;
  localparam int LW = 8;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [LW-1:0]   len;
  logic [N-1:0]    data_in;
  logic            in_valid;
  logic            in_ready;
  logic [LW+K-1:0] sum;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            err;

  int n_cmp = 0;
  int n_bad = 0;

  sc_accum_sequencer #(.K(K), .N(N), .LW(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic iv, input logic bz,
                           input logic ov, input logic er);
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, iv});
    chk({tag, ".busy"},      {31'd0, busy},      {31'd0, bz});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".err"},       {31'd0, err},       {31'd0, er});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; data_in = '0;
    in_valid = 1'b0; out_ready = 1'b0;

    // reset state
    step();
    chk_flags("rst", 0, 0, 0, 0);
    chk("rst.sum", 32'(sum), 0);
    rst_n = 1'b1;
    step();

    // len=4, all-ones beats, continuous valid
    start = 1'b1; len = 8'd4; data_in = 8'hFF; in_valid = 1'b1;
    step();
    start = 1'b0;
    chk_flags("w4.run", 1, 1, 0, 0);
    chk("w4.sum0", 32'(sum), 0);
    step();
    chk("w4.sum1", 32'(sum), 8);
    step();
    step();
    chk("w4.ov_early", {31'd0, out_valid}, 0);
    step();
    chk_flags("w4.done", 0, 1, 1, 0);
    chk("w4.sum", 32'(sum), 32);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_flags("w4.idle", 0, 0, 0, 0);

    // len=3 with two-cycle bubbles between beats
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    data_in = 8'h01; in_valid = 1'b1;
    step();
    chk("b3.sum1", 32'(sum), 1);
    data_in = 8'hFF; in_valid = 1'b0;
    step();
    step();
    chk("b3.bubble1", 32'(sum), 1);
    data_in = 8'h0F; in_valid = 1'b1;
    step();
    chk("b3.sum2", 32'(sum), 5);
    data_in = 8'hFF; in_valid = 1'b0;
    step();
    step();
    chk("b3.bubble2", 32'(sum), 5);
    chk("b3.ov_wait", {31'd0, out_valid}, 0);
    data_in = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("b3.ov", {31'd0, out_valid}, 1);
    chk("b3.sum", 32'(sum), 9);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("b3.idle", {31'd0, busy}, 0);

    // len=0 rejected start
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0;
    chk_flags("z.err", 0, 0, 0, 1);
    chk("z.sum", 32'(sum), 9);
    step();
    chk_flags("z.after", 0, 0, 0, 0);

    // len=255 of all-ones beats
    start = 1'b1; len = 8'd255; data_in = 8'hFF; in_valid = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 254; i++) step();
    chk("big.ov_early", {31'd0, out_valid}, 0);
    chk("big.sum254", 32'(sum), 2032);
    step();
    chk("big.ov", {31'd0, out_valid}, 1);
    chk("big.sum", 32'(sum), 2040);

    // DONE holds against start and stalled consumer
    start = 1'b1; len = 8'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_flags("hold", 0, 1, 1, 0);
      chk("hold.sum", 32'(sum), 2040);
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_flags("hold.idle", 0, 0, 0, 0);
    chk("hold.sum_kept", 32'(sum), 2040);

    // asynchronous reset mid-RUN
    start = 1'b1; len = 8'd4; data_in = 8'hFF; in_valid = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("ar.sum2", 32'(sum), 16);
    #2 rst_n = 1'b0;
    #1;
    chk_flags("ar.cleared", 0, 0, 0, 0);
    chk("ar.sum", 32'(sum), 0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // fresh window after reset
    start = 1'b1; len = 8'd1; data_in = 8'h03; in_valid = 1'b1;
    step();
    start = 1'b0;
    chk("post.sum0", 32'(sum), 0);
    step();
    in_valid = 1'b0;
    chk_flags("post.done", 0, 1, 1, 0);
    chk("post.sum", 32'(sum), 2);

    // asynchronous reset during DONE
    #2 rst_n = 1'b0;
    #1;
    chk_flags("ard.cleared", 0, 0, 0, 0);
    chk("ard.sum", 32'(sum), 0);
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
